pc_redirect_unit: RTL

Consumes the branch predictor's fetch-side and execute-side outputs and owns the fetch PC. Every cycle it selects the next fetch PC from four sources, in priority order: EXE correction, ID unpredicted jump, IF prediction, then sequential. It carries PC and valid bits through the IF/ID/EXE stages, generates squash strobes, and keeps branch and misprediction statistics. It sits between the predictor and the fetch/decode pipeline registers.

---
 rtl/pc_redirect_unit.sv | 106 ++++++++++
 1 files changed

// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: owns the fetch PC, picks the next one from EXE/ID/IF/sequential
// sources, tracks IF/ID/EXE slot validity and keeps branch statistics.
module pc_redirect_unit #(
    parameter int PC_W = 10,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             nrst,
    input  logic             en,
    input  logic             if_prediction,
    input  logic [PC_W-1:0]  if_PBT,
    input  logic             id_is_jump,
    input  logic             id_jump_in_bht,
    input  logic [PC_W-1:0]  id_branchtarget,
    input  logic             exe_is_branch,
    input  logic [1:0]       exe_correction,
    input  logic [PC_W-1:0]  exe_PBT,
    input  logic [PC_W-1:0]  exe_CNI,
    output logic [PC_W-1:0]  if_PC,
    output logic [PC_W-1:0]  id_PC,
    output logic [PC_W-1:0]  exe_PC,
    output logic             id_valid,
    output logic             exe_valid,
    output logic             flush_if,
    output logic             flush_id,
    output logic [1:0]       redirect_src,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispredict_cnt,
    output logic [CNT_W-1:0] jump_redir_cnt
);
    typedef enum logic [1:0] {BOOT, RUN, REFILL} state_t;

    state_t          state, state_nx;
    logic [1:0]      refill_cnt, refill_nx;
    logic            if_valid;
    logic            exe_fix, id_fix, if_take;
    logic [PC_W-1:0] next_pc;

    assign exe_fix = exe_valid & exe_is_branch & exe_correction[1];
    assign id_fix  = id_valid & id_is_jump & ~id_jump_in_bht & ~exe_fix;
    assign if_take = if_valid & if_prediction & ~exe_fix & ~id_fix;

    always_ff @(posedge CLK) begin
        if (!nrst) begin
            state      <= BOOT;
            refill_cnt <= 2'd0;
        end else if (en) begin
            state      <= state_nx;
            refill_cnt <= refill_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        refill_nx = refill_cnt;
        if (exe_fix) begin
            state_nx  = REFILL;
            refill_nx = 2'd2;
        end else begin
            case (state)
                BOOT:    state_nx = RUN;
                REFILL: begin
                    refill_nx = refill_cnt - 2'd1;
                    state_nx  = (refill_cnt == 2'd1) ? RUN : REFILL;
                end
                default: state_nx = state;
            endcase
        end
    end

    always_comb if_valid = (state != BOOT);

    // The boot bubble holds the PC so the instruction at RESET_PC is fetched validly next cycle
    always_comb begin
        next_pc = exe_fix ? (exe_correction[0] ? exe_PBT : exe_CNI)
                : id_fix  ? id_branchtarget
                : if_take ? if_PBT
                : if_valid ? if_PC + PC_W'(1) : if_PC;
        redirect_src = exe_fix ? 2'b11 : id_fix ? 2'b10 : if_take ? 2'b01 : 2'b00;
        flush_if = en & (exe_fix | id_fix);
        flush_id = en & exe_fix;
    end

    always_ff @(posedge CLK) begin
        if (!nrst) begin
            if_PC          <= RESET_PC;
            id_PC          <= '0;
            exe_PC         <= '0;
            id_valid       <= 1'b0;
            exe_valid      <= 1'b0;
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
            jump_redir_cnt <= '0;
        end else if (en) begin
            if_PC          <= next_pc;
            id_PC          <= if_PC;
            exe_PC         <= id_PC;
            id_valid       <= if_valid & ~(exe_fix | id_fix);
            exe_valid      <= id_valid & ~exe_fix;
            branch_cnt     <= branch_cnt + CNT_W'(exe_valid & exe_is_branch & ~&branch_cnt);
            mispredict_cnt <= mispredict_cnt + CNT_W'(exe_fix & ~&mispredict_cnt);
            jump_redir_cnt <= jump_redir_cnt + CNT_W'(id_fix & ~&jump_redir_cnt);
        end
    end
endmodule
